// File: rtl/control_unit_pkg.sv
// Shared decode definitions for the control unit: ALU opcodes, memory
// access size encodings, instruction classes and the control word layout.
package control_unit_pkg;

   // ALU operation codes
   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_TEQ = 4'b1001;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_CMN = 4'b1011;

   // Memory access sizes
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      CL_NOP    = 3'd0,
      CL_DP     = 3'd1,
      CL_LDST   = 3'd2,
      CL_HALF   = 3'd3,
      CL_BRANCH = 3'd4
   } cu_class_e;

   // Control word, MSB first in the order the outputs are listed
   typedef struct packed {
      logic       se_id;
      logic       li_id;
      logic       rf_id;
      logic       b_id;
      logic       r_w;
      logic       b_l;
      logic [3:0] opcode;
      logic [1:0] size;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // Compare-class opcodes (TST..CMN) only set flags, never write a register
   function automatic logic is_compare(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction-in / control-out bundle of the control unit.
// master: instruction source and control consumer; slave: control_unit.
interface control_unit_if;
   logic [31:0] ir;
   logic        se_id;
   logic        li_id;
   logic        rf_id;
   logic        b_id;
   logic        r_w;
   logic        b_l;
   logic [3:0]  opcode;
   logic [1:0]  size;

   modport master (
      output ir,
      input  se_id, li_id, rf_id, b_id, r_w, b_l, opcode, size
   );

   modport slave (
      input  ir,
      output se_id, li_id, rf_id, b_id, r_w, b_l, opcode, size
   );
endinterface

// File: rtl/control_unit_decoder.sv
// cu_decoder: purely combinational instruction decoder feeding the
// control_unit output register. Condition field ir[31:28] does not affect
// the decode. Macro CU_HALFWORD_EN enables halfword/signed load/store decode.
module cu_decoder
   import control_unit_pkg::*;
(
   input  logic [31:0] i_ir,
   output ctrl_t       o_ctrl
);

   cu_class_e w_class;

   // Classify the instruction word
   always_comb begin
      w_class = CL_NOP;
      if (i_ir == '0)
         w_class = CL_NOP;
`ifdef CU_HALFWORD_EN
      else if (i_ir[27:25] == 3'b000 && i_ir[7] && i_ir[4])
         w_class = CL_HALF;
`endif
      else if (i_ir[27:26] == 2'b00)
         w_class = CL_DP;
      else if (i_ir[27:26] == 2'b01)
         w_class = (i_ir[25] && i_ir[4]) ? CL_NOP : CL_LDST;
      else if (i_ir[27:25] == 3'b101)
         w_class = CL_BRANCH;
      else
         w_class = CL_NOP;
   end

   // Produce the control word for the selected class
   always_comb begin
      o_ctrl = CTRL_NOP;
      case (w_class)
         CL_DP: begin
            o_ctrl.opcode = i_ir[24:21];
            o_ctrl.se_id  = i_ir[20];
            o_ctrl.rf_id  = ~is_compare(i_ir[24:21]);
            o_ctrl.size   = SZ_WORD;
         end
         CL_LDST, CL_HALF: begin
            o_ctrl.opcode = i_ir[23] ? OP_ADD : OP_SUB;
            o_ctrl.li_id  = i_ir[20];
            o_ctrl.rf_id  = i_ir[20];
            o_ctrl.r_w    = ~i_ir[20];
            if (w_class == CL_HALF)
               o_ctrl.size = SZ_HALF;
            else
               o_ctrl.size = i_ir[22] ? SZ_BYTE : SZ_WORD;
         end
         CL_BRANCH: begin
            o_ctrl.b_id   = 1'b1;
            o_ctrl.b_l    = i_ir[24];
            o_ctrl.rf_id  = i_ir[24];
            o_ctrl.opcode = OP_ADD;
            o_ctrl.size   = SZ_WORD;
         end
         default: o_ctrl = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: ID-stage control decode with registered outputs (one cycle
// latency, no combinational path from ir). Asynchronous active-low reset
// clears outputs to NOP. Macro CU_HALFWORD_EN enables halfword decode.
module control_unit
   import control_unit_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   control_unit_if.slave  bus
);

   ctrl_t w_ctrl;
   ctrl_t r_ctrl;

   cu_decoder u_decoder (
      .i_ir   (bus.ir),
      .o_ctrl (w_ctrl)
   );

   // Output register: captures the decoded word each cycle, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ctrl <= CTRL_NOP;
      else
         r_ctrl <= w_ctrl;
   end

   assign bus.se_id  = r_ctrl.se_id;
   assign bus.li_id  = r_ctrl.li_id;
   assign bus.rf_id  = r_ctrl.rf_id;
   assign bus.b_id   = r_ctrl.b_id;
   assign bus.r_w    = r_ctrl.r_w;
   assign bus.b_l    = r_ctrl.b_l;
   assign bus.opcode = r_ctrl.opcode;
   assign bus.size   = r_ctrl.size;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction tables, async reset,
// hold-without-edge and a random back-to-back stream, all checked through
// a scoreboard queue of expected control words.
module tb_control_unit;
   import control_unit_pkg::*;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   ctrl_t sb[$];

   control_unit_if bus();

   control_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctrl_t mk(input logic se, input logic li, input logic rf,
                                input logic b, input logic rw, input logic bl,
                                input logic [3:0] op, input logic [1:0] sz);
      return {se, li, rf, b, rw, bl, op, sz};
   endfunction

   function automatic ctrl_t observe();
      return {bus.se_id, bus.li_id, bus.rf_id, bus.b_id, bus.r_w, bus.b_l,
              bus.opcode, bus.size};
   endfunction

   // Independent reference decode for random stimulus
   function automatic ctrl_t model(input logic [31:0] w);
      ctrl_t m;
      logic  hw;
      m  = '0;
      hw = 1'b0;
`ifdef CU_HALFWORD_EN
      hw = (w[27:25] == 3'b000) && w[7] && w[4];
`endif
      if (w != 32'h0) begin
         if (hw)
            m = mk(0, w[20], w[20], 0, !w[20], 0, w[23] ? 4'b0100 : 4'b0010, 2'b01);
         else begin
            case (w[27:25])
               3'b000, 3'b001:
                  m = mk(w[20], 0, !(w[24:21] >= 4'd8 && w[24:21] <= 4'd11), 0, 0, 0,
                         w[24:21], 2'b10);
               3'b010, 3'b011:
                  if (!(w[25] && w[4]))
                     m = mk(0, w[20], w[20], 0, !w[20], 0, w[23] ? 4'b0100 : 4'b0010,
                            w[22] ? 2'b00 : 2'b10);
               3'b101:
                  m = mk(0, 0, w[24], 1, 0, w[24], 4'b0100, 2'b10);
               default: m = '0;
            endcase
         end
      end
      return m;
   endfunction

   // Drive one instruction at the falling edge, queue its expectation, and
   // advance to just after the capturing rising edge
   task automatic issue(input logic [31:0] w, input ctrl_t e);
      @(negedge clk);
      bus.ir = w;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ctrl_t got, exp;
      rst_n  = 1'b0;
      bus.ir = 32'hE0825005;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         sb.push_back(CTRL_NOP);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL reset[%0d] got=%h required=%h", i, got, exp);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_data_processing();
      logic [31:0] irs [7] = '{32'hE0825005, 32'hE2533001, 32'h00825005,
                               32'hE3110001, 32'hE1710002, 32'hE0E00001,
                               32'hE1800001};
      ctrl_t exps [7] = '{mk(0,0,1,0,0,0,4'b0100,2'b10),
                          mk(1,0,1,0,0,0,4'b0010,2'b10),
                          mk(0,0,1,0,0,0,4'b0100,2'b10),
                          mk(1,0,0,0,0,0,4'b1000,2'b10),
                          mk(1,0,0,0,0,0,4'b1011,2'b10),
                          mk(0,0,1,0,0,0,4'b0111,2'b10),
                          mk(0,0,1,0,0,0,4'b1100,2'b10)};
      ctrl_t got, exp;
      for (int i = 0; i < 7; i++) begin
         issue(irs[i], exps[i]);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL dp[%0d] ir=%h got=%h required=%h", i, irs[i], got, exp);
         end
      end
   endtask

   task automatic test_load_store();
      logic [31:0] irs [4] = '{32'hE5C15003, 32'hE5D15003, 32'hE5110004,
                               32'hE7910002};
      ctrl_t exps [4] = '{mk(0,0,0,0,1,0,4'b0100,2'b00),
                          mk(0,1,1,0,0,0,4'b0100,2'b00),
                          mk(0,1,1,0,0,0,4'b0010,2'b10),
                          mk(0,1,1,0,0,0,4'b0100,2'b10)};
      ctrl_t got, exp;
      for (int i = 0; i < 4; i++) begin
         issue(irs[i], exps[i]);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL ldst[%0d] ir=%h got=%h required=%h", i, irs[i], got, exp);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] irs [2] = '{32'h1AFFFFFD, 32'hDB000001};
      ctrl_t exps [2] = '{mk(0,0,0,1,0,0,4'b0100,2'b10),
                          mk(0,0,1,1,0,1,4'b0100,2'b10)};
      ctrl_t got, exp;
      for (int i = 0; i < 2; i++) begin
         issue(irs[i], exps[i]);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL branch[%0d] ir=%h got=%h required=%h", i, irs[i], got, exp);
         end
      end
   endtask

   task automatic test_nop_unsupported();
      logic [31:0] irs [5] = '{32'h00000000, 32'hE7F000F0, 32'hE8BD8000,
                               32'hEC000000, 32'hEF000000};
      ctrl_t got, exp;
      for (int i = 0; i < 5; i++) begin
         issue(irs[i], CTRL_NOP);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL nop[%0d] ir=%h got=%h required=%h", i, irs[i], got, exp);
         end
      end
   endtask

   task automatic test_halfword();
      logic [31:0] irs [3] = '{32'hE1C150B3, 32'hE1D150B3, 32'hE3A000B0};
`ifdef CU_HALFWORD_EN
      ctrl_t exps [3] = '{mk(0,0,0,0,1,0,4'b0100,2'b01),
                          mk(0,1,1,0,0,0,4'b0100,2'b01),
                          mk(0,0,1,0,0,0,4'b1101,2'b10)};
`else
      ctrl_t exps [3] = '{mk(0,0,1,0,0,0,4'b1110,2'b10),
                          mk(1,0,1,0,0,0,4'b1110,2'b10),
                          mk(0,0,1,0,0,0,4'b1101,2'b10)};
`endif
      ctrl_t got, exp;
      for (int i = 0; i < 3; i++) begin
         issue(irs[i], exps[i]);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL half[%0d] ir=%h got=%h required=%h", i, irs[i], got, exp);
         end
      end
   endtask

   task automatic test_hold_no_edge();
      ctrl_t got, exp;
      ctrl_t add_e = mk(0,0,1,0,0,0,4'b0100,2'b10);
      ctrl_t bne_e = mk(0,0,0,1,0,0,4'b0100,2'b10);
      issue(32'hE0825005, add_e);
      exp = sb.pop_front();
      got = observe();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL hold_setup got=%h required=%h", got, exp);
      end
      // ir changes between edges: outputs must keep the ADD decode
      bus.ir = 32'h1AFFFFFD;
      sb.push_back(add_e);
      #3;
      exp = sb.pop_front();
      got = observe();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL hold_no_edge got=%h required=%h", got, exp);
      end
      sb.push_back(bne_e);
      @(posedge clk);
      #1;
      exp = sb.pop_front();
      got = observe();
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL hold_next_edge got=%h required=%h", got, exp);
      end
   endtask

   task automatic test_async_reset();
      ctrl_t got, exp;
      string names [4] = '{"arst_immediate", "arst_over_edge", "arst_released",
                           "arst_first_edge"};
      // outputs currently hold the BNE decode; ir stays BNE throughout
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin #2; rst_n = 1'b0; #1; end
            1: begin @(posedge clk); #1; end
            2: begin #2; rst_n = 1'b1; #1; end
            default: begin @(posedge clk); #1; end
         endcase
         sb.push_back((i == 3) ? mk(0,0,0,1,0,0,4'b0100,2'b10) : CTRL_NOP);
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h required=%h", names[i], got, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      ctrl_t got, exp;
      for (int i = 0; i < 48; i++) begin
         w = $urandom;
         if (i % 8 == 0) w[7:4] = 4'b1011;
         issue(w, model(w));
         exp = sb.pop_front();
         got = observe();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL b2b[%0d] ir=%h got=%h required=%h", i, w, got, exp);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      bus.ir      = '0;
      test_reset();
      test_data_processing();
      test_load_store();
      test_branch();
      test_nop_unsupported();
      test_halfword();
      test_hold_no_edge();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout vectors=%0d required=completion", vectors);
      $fatal(1, "simulation time limit reached");
   end

endmodule
